sprite_blitter: RTL and testbench
=================================

// Module: sprite_blitter
// PURPOSE
//  Draws one sprite from a sprite ROM onto the VGA framebuffer at a requested screen origin, one pixel per clock.
//  Adds a start/busy/done handshake, optional horizontal mirroring, transparent-colour skipping and screen-edge clipping.
//  Sits between game logic (which requests the draw) and the VGA adapter plot port.
//  Drives the address inputs of a 1-cycle-latency sprite_ram_module.
// PARAMETERS
//  WIDTH_X      8    screen x coordinate width
//  WIDTH_Y      7    screen y coordinate width
//  SCREEN_X     160  screen width in pixels; valid x is 0..SCREEN_X-1
//  SCREEN_Y     120  screen height in pixels; valid y is 0..SCREEN_Y-1
//  SPR_WX       4    sprite-local x width
//  SPR_WY       4    sprite-local y width
//  SPRITE_W     16   sprite width in pixels; 1..2**SPR_WX
//  SPRITE_H     16   sprite height in pixels; 1..2**SPR_WY
//  COLOR_W      3    colour width
//  TRANSPARENT  3'b000  ROM colour that is never plotted
// PORTS
//  clk        in   1         single clock; all logic on posedge
//  reset      in   1         synchronous, active-high
//  start      in   1         draw request; sampled only when busy=0
//  origin_x   in   WIDTH_X   screen x of sprite pixel (0,0); latched on start
//  origin_y   in   WIDTH_Y   screen y of sprite pixel (0,0); latched on start
//  flip_x     in   1         1 = mirror sprite horizontally; latched on start
//  busy       out  1         draw in progress
//  done       out  1         one-cycle pulse when the last pixel is presented
//  rom_x      out  SPR_WX    sprite ROM column address
//  rom_y      out  SPR_WY    sprite ROM row address
//  rom_color  in   COLOR_W   ROM data; valid 1 cycle after rom_x/rom_y
//  vga_x      out  WIDTH_X   plot x
//  vga_y      out  WIDTH_Y   plot y
//  vga_color  out  COLOR_W   plot colour
//  vga_plot   out  1         write enable for vga_x/vga_y/vga_color
// BEHAVIOUR
//  Reset:
//   - Clears every output to 0, state IDLE, pipeline valid 0.
//   - Reset mid-draw aborts immediately: no further vga_plot, no done pulse.
//  Accepting a draw:
//   - start is accepted on the edge where state=IDLE and start=1.
//   - On that edge latch origin_x, origin_y, flip_x; set counters sx=sy=0; enter SCAN.
//  States (IDLE -> SCAN -> DRAIN -> IDLE):
//   - busy=1 in SCAN and DRAIN.
//   - start while busy=1 is ignored and not queued.
//  Scan (SCAN):
//   - Each cycle presents one pixel: rom_y=sy.
//   - rom_x=sx, or SPRITE_W-1-sx when flip_x=1.
//   - Order is row-major: sx 0..SPRITE_W-1, then sx wraps to 0 and sy increments.
//   - After pixel (SPRITE_W-1, SPRITE_H-1) go to DRAIN.
//  Pipeline:
//   - Stage 1 delays sx, sy and valid by 1 cycle to align with rom_color.
//   - Stage 2 registers the vga_* outputs.
//   - Pixel k (0-based) appears on vga_* exactly k+2 cycles after the accepting edge.
//   - Total draw = SPRITE_W*SPRITE_H+2 cycles including DRAIN.
//  Plot rule:
//   - Screen coordinates: px = origin_x+sx, computed WIDTH_X+1 bits wide; py = origin_y+sy, computed WIDTH_Y+1 bits wide.
//   - vga_plot=1 only if stage-1 valid, rom_color != TRANSPARENT, px<SCREEN_X and py<SCREEN_Y.
//   - Clipped or transparent pixels still take their cycle: vga_plot=0 and vga_x/vga_y/vga_color hold their last values.
//  done:
//   - High for exactly one cycle, coincident with the vga_* cycle of the last pixel, whether or not that pixel plotted.
//   - busy falls on the same edge that done falls.
//   - A new start is accepted in that same cycle at the earliest, so back-to-back draws have no idle gap beyond that cycle.
//  Degenerate sprite: SPRITE_W=SPRITE_H=1 is a legal 1-pixel draw; done 2 cycles after the accepting edge.
// STRUCTURE
//  - Shared package vga_pkg holds: COLOR_W, TRANSPARENT, SCREEN_X/SCREEN_Y defaults, and the state encoding localparams IDLE/SCAN/DRAIN.
//  - One sub-module: blit_scan_counter (sx/sy row-major counter with en, wrap and last flag).
//  - FSM, flip, clip and output registers stay in sprite_blitter.
//  - The ROM itself is external (sprite_ram_module).
// TESTING (bench models ROM as 1-cycle registered lookup; SPRITE_W=4, SPRITE_H=2, SCREEN 160x120)
//  - Opaque sprite, origin (10,20), flip 0, start 1 cycle:
//    8 plots (10..13,20),(10..13,21) on cycles 2..9; done cycle 9 only; busy cycles 1..9.
//  - flip_x=1, row 0 ROM colours 1,2,3,4:
//    vga_color sequence 4,3,2,1 at x 10..13; rom_x sequence 3,2,1,0.
//  - Clipping, origin (158,119):
//    only (158,119),(159,119) plot; the other 6 cycles vga_plot=0; done still cycle 9.
//  - TRANSPARENT at sprite pixel (1,0):
//    no plot on cycle 3; all other 7 pixels plot.
//  - start held high through a draw:
//    second draw begins the edge done is seen; start pulses during busy are ignored.
//  - Reset asserted at cycle 5 of a draw:
//    next cycle all outputs 0, busy=0; no done; a fresh start draws all 8 pixels.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA types and defaults.
// Used by the sprite blitter and its scan counter.
package vga_pkg;

  localparam int COLOR_W = 3;
  localparam logic [COLOR_W-1:0] TRANSPARENT = 3'b000;
  localparam int SCREEN_X = 160;
  localparam int SCREEN_Y = 120;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/blit_scan_counter.sv
// Row-major sprite-local pixel counter.
// Walks sx across a row, then steps sy; wraps after the last pixel.
module blit_scan_counter #(
  parameter int SPR_WX   = 4,
  parameter int SPR_WY   = 4,
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  output logic [SPR_WX-1:0] sx,
  output logic [SPR_WY-1:0] sy,
  output logic              last
);

  localparam logic [SPR_WX-1:0] XMAX = SPR_WX'(SPRITE_W - 1);
  localparam logic [SPR_WY-1:0] YMAX = SPR_WY'(SPRITE_H - 1);

  assign last = (sx == XMAX) && (sy == YMAX);

  // Advance one pixel per enabled cycle, wrapping to (0,0) after the last.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      sx <= '0;
      sy <= '0;
    end else if (en) begin
      if (sx == XMAX) begin
        sx <= '0;
        sy <= last ? '0 : sy + SPR_WY'(1);
      end else begin
        sx <= sx + SPR_WX'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: scans a sprite ROM and plots it at a screen origin.
// Handles mirroring, transparent skipping and screen-edge clipping.
module sprite_blitter #(
  parameter int WIDTH_X  = 8,
  parameter int WIDTH_Y  = 7,
  parameter int SCREEN_X = vga_pkg::SCREEN_X,
  parameter int SCREEN_Y = vga_pkg::SCREEN_Y,
  parameter int SPR_WX   = 4,
  parameter int SPR_WY   = 4,
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16,
  parameter int COLOR_W  = vga_pkg::COLOR_W,
  parameter logic [COLOR_W-1:0] TRANSPARENT = vga_pkg::TRANSPARENT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH_X-1:0] origin_x,
  input  logic [WIDTH_Y-1:0] origin_y,
  input  logic               flip_x,
  output logic               busy,
  output logic               done,
  output logic [SPR_WX-1:0]  rom_x,
  output logic [SPR_WY-1:0]  rom_y,
  input  logic [COLOR_W-1:0] rom_color,
  output logic [WIDTH_X-1:0] vga_x,
  output logic [WIDTH_Y-1:0] vga_y,
  output logic [COLOR_W-1:0] vga_color,
  output logic               vga_plot
);

  import vga_pkg::*;

  localparam logic [SPR_WX-1:0] XMAX = SPR_WX'(SPRITE_W - 1);
  localparam logic [WIDTH_X:0] SCR_X = (WIDTH_X + 1)'(SCREEN_X);
  localparam logic [WIDTH_Y:0] SCR_Y = (WIDTH_Y + 1)'(SCREEN_Y);

  state_t state, state_nx;
  logic accept, scan_en, last;
  logic [SPR_WX-1:0] sx, s1_sx;
  logic [SPR_WY-1:0] sy, s1_sy;
  logic [WIDTH_X-1:0] ox;
  logic [WIDTH_Y-1:0] oy;
  logic flip;
  logic s1_valid, s1_last;
  logic [WIDTH_X:0] px;
  logic [WIDTH_Y:0] py;
  logic hit;

  blit_scan_counter #(
    .SPR_WX  (SPR_WX),
    .SPR_WY  (SPR_WY),
    .SPRITE_W(SPRITE_W),
    .SPRITE_H(SPRITE_H)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (accept),
    .en   (scan_en),
    .sx   (sx),
    .sy   (sy),
    .last (last)
  );

  assign busy  = (state != IDLE);
  assign rom_x = flip ? XMAX - sx : sx;
  assign rom_y = sy;

  // Next state; a draw may chain straight off the done cycle.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    scan_en  = 1'b0;
    unique case (state)
      IDLE: begin
        accept = start;
      end
      SCAN: begin
        scan_en = 1'b1;
        if (last) state_nx = DRAIN;
      end
      DRAIN: begin
        if (done) begin
          accept   = start;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (accept) state_nx = SCAN;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Capture draw parameters on the accepting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ox   <= '0;
      oy   <= '0;
      flip <= 1'b0;
    end else if (accept) begin
      ox   <= origin_x;
      oy   <= origin_y;
      flip <= flip_x;
    end
  end

  // Stage 1: align scan position with the ROM read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_sx    <= '0;
      s1_sy    <= '0;
    end else begin
      s1_valid <= (state == SCAN);
      s1_last  <= last;
      s1_sx    <= sx;
      s1_sy    <= sy;
    end
  end

  assign px  = {1'b0, ox} + (WIDTH_X + 1)'(s1_sx);
  assign py  = {1'b0, oy} + (WIDTH_Y + 1)'(s1_sy);
  assign hit = s1_valid && (rom_color != TRANSPARENT)
            && (px < SCR_X) && (py < SCR_Y);

  // Stage 2: plot port; coordinates/colour hold on skipped pixels.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_plot  <= 1'b0;
      done      <= 1'b0;
      vga_x     <= '0;
      vga_y     <= '0;
      vga_color <= '0;
    end else begin
      vga_plot <= hit;
      done     <= s1_valid && s1_last;
      if (hit) begin
        vga_x     <= px[WIDTH_X-1:0];
        vga_y     <= py[WIDTH_Y-1:0];
        vga_color <= rom_color;
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter with a 4x2 sprite.
// ROM modelled as a 1-cycle registered lookup.
module tb_sprite_blitter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] origin_x = '0;
  logic [6:0] origin_y = '0;
  logic       flip_x = 1'b0;
  logic       busy, done, vga_plot;
  logic [3:0] rom_x, rom_y;
  logic [2:0] rom_color;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_color;

  logic [2:0] rom_mem [0:255];

  int errors = 0;
  int checks = 0;

  logic       p_a [24];
  logic       d_a [24];
  logic       b_a [24];
  logic [7:0] x_a [24];
  logic [6:0] y_a [24];
  logic [2:0] c_a [24];
  logic [3:0] rx_a [24];
  logic [3:0] ry_a [24];

  sprite_blitter #(
    .SPRITE_W(4),
    .SPRITE_H(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .origin_x (origin_x),
    .origin_y (origin_y),
    .flip_x   (flip_x),
    .busy     (busy),
    .done     (done),
    .rom_x    (rom_x),
    .rom_y    (rom_y),
    .rom_color(rom_color),
    .vga_x    (vga_x),
    .vga_y    (vga_y),
    .vga_color(vga_color),
    .vga_plot (vga_plot)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_color <= rom_mem[{rom_y, rom_x}];

  function automatic logic [2:0] rom_at(input int x, input int y);
    return rom_mem[y * 16 + x];
  endfunction

  task automatic chk(input string tag, input int c,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, c, obs, exp);
    end
  endtask

  // Start a draw and record outputs for cycles 0..n-1 after the accept edge.
  task automatic draw(input logic [7:0] ox, input logic [6:0] oy,
                      input logic fl, input int n, input int s_on,
                      input int s_off, input int rst_at);
    @(negedge clk);
    origin_x = ox;
    origin_y = oy;
    flip_x   = fl;
    start    = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < n; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      p_a[c]  = vga_plot;
      d_a[c]  = done;
      b_a[c]  = busy;
      x_a[c]  = vga_x;
      y_a[c]  = vga_y;
      c_a[c]  = vga_color;
      rx_a[c] = rom_x;
      ry_a[c] = rom_y;
      start = (c >= s_on) && (c < s_off);
      reset = (c == rst_at);
    end
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = 3'd7;
    rom_mem[0]  = 3'd1; rom_mem[1]  = 3'd2;
    rom_mem[2]  = 3'd3; rom_mem[3]  = 3'd4;
    rom_mem[16] = 3'd5; rom_mem[17] = 3'd6;
    rom_mem[18] = 3'd7; rom_mem[19] = 3'd7;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 0, busy, 0);
    chk("rst_done", 0, done, 0);
    chk("rst_plot", 0, vga_plot, 0);
    chk("rst_x", 0, vga_x, 0);
    chk("rst_y", 0, vga_y, 0);
    chk("rst_col", 0, vga_color, 0);
    chk("rst_romx", 0, rom_x, 0);
    chk("rst_romy", 0, rom_y, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Opaque draw at (10,20)
    draw(8'd10, 7'd20, 1'b0, 12, 0, 0, -1);
    for (int c = 0; c < 12; c++) begin
      chk("t1_done", c, d_a[c], c == 9);
      chk("t1_plot", c, p_a[c], c >= 2 && c <= 9);
      if (c >= 1) chk("t1_busy", c, b_a[c], c <= 9);
    end
    for (int k = 0; k < 8; k++) begin
      chk("t1_x", k + 2, x_a[k+2], 10 + k % 4);
      chk("t1_y", k + 2, y_a[k+2], 20 + k / 4);
      chk("t1_col", k + 2, c_a[k+2], rom_at(k % 4, k / 4));
      chk("t1_romx", k, rx_a[k], k % 4);
      chk("t1_romy", k, ry_a[k], k / 4);
    end

    // Mirrored draw
    draw(8'd10, 7'd20, 1'b1, 12, 0, 0, -1);
    for (int k = 0; k < 8; k++) begin
      chk("t2_x", k + 2, x_a[k+2], 10 + k % 4);
      chk("t2_col", k + 2, c_a[k+2], rom_at(3 - k % 4, k / 4));
      chk("t2_romx", k, rx_a[k], 3 - k % 4);
    end
    chk("t2_col0", 2, c_a[2], 4);
    chk("t2_col3", 5, c_a[5], 1);
    chk("t2_done", 9, d_a[9], 1);

    // Clipping at bottom-right corner
    draw(8'd158, 7'd119, 1'b0, 12, 0, 0, -1);
    for (int c = 0; c < 12; c++) begin
      chk("t3_plot", c, p_a[c], c == 2 || c == 3);
      chk("t3_done", c, d_a[c], c == 9);
      if (c >= 3) chk("t3_xhold", c, x_a[c], 159);
      if (c >= 2) chk("t3_y", c, y_a[c], 119);
    end
    chk("t3_x0", 2, x_a[2], 158);
    chk("t3_col0", 2, c_a[2], 1);
    chk("t3_colh", 9, c_a[9], 2);

    // Transparent pixel at (1,0)
    rom_mem[1] = 3'd0;
    draw(8'd10, 7'd20, 1'b0, 12, 0, 0, -1);
    for (int c = 0; c < 12; c++)
      chk("t4_plot", c, p_a[c], c >= 2 && c <= 9 && c != 3);
    chk("t4_xhold", 3, x_a[3], 10);
    chk("t4_colhold", 3, c_a[3], 1);
    chk("t4_x2", 4, x_a[4], 12);
    chk("t4_done", 9, d_a[9], 1);
    rom_mem[1] = 3'd2;

    // start held high: second draw chains off done
    draw(8'd10, 7'd20, 1'b0, 22, 0, 12, -1);
    for (int c = 0; c < 22; c++) begin
      chk("t5_done", c, d_a[c], c == 9 || c == 19);
      chk("t5_plot", c, p_a[c],
          (c >= 2 && c <= 9) || (c >= 12 && c <= 19));
      if (c >= 1) chk("t5_busy", c, b_a[c], c <= 19);
    end
    chk("t5_x", 12, x_a[12], 10);
    chk("t5_romx", 11, rx_a[11], 1);

    // start pulse while busy is ignored
    draw(8'd40, 7'd50, 1'b0, 12, 4, 5, -1);
    for (int c = 0; c < 12; c++) begin
      chk("t6_done", c, d_a[c], c == 9);
      chk("t6_plot", c, p_a[c], c >= 2 && c <= 9);
      if (c >= 1) chk("t6_busy", c, b_a[c], c <= 9);
    end
    chk("t6_x", 9, x_a[9], 43);
    chk("t6_y", 9, y_a[9], 51);

    // Reset mid-draw
    draw(8'd10, 7'd20, 1'b0, 12, 0, 0, 5);
    chk("t7_plot5", 5, p_a[5], 1);
    chk("t7_x6", 6, x_a[6], 0);
    chk("t7_y6", 6, y_a[6], 0);
    chk("t7_col6", 6, c_a[6], 0);
    chk("t7_romx6", 6, rx_a[6], 0);
    chk("t7_romy6", 6, ry_a[6], 0);
    for (int c = 6; c < 12; c++) begin
      chk("t7_done", c, d_a[c], 0);
      chk("t7_plot", c, p_a[c], 0);
      chk("t7_busy", c, b_a[c], 0);
    end
    draw(8'd10, 7'd20, 1'b0, 12, 0, 0, -1);
    for (int c = 0; c < 12; c++) begin
      chk("t7b_plot", c, p_a[c], c >= 2 && c <= 9);
      chk("t7b_done", c, d_a[c], c == 9);
    end
    chk("t7b_x", 9, x_a[9], 13);
    chk("t7b_y", 9, y_a[9], 21);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
